// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 datapath: block/round sizes, the
//   message-scheduler state encoding and the small-sigma mixing functions
//   (also intended for reuse by the hash-output stage).
package sha256_pkg;

  localparam int BLOCK_WORDS = 16;  // 32-bit words per 512-bit message block
  localparam int ROUNDS      = 64;  // schedule words per block for full SHA-256

  typedef enum logic {
    LOAD = 1'b0,  // collecting the 16 message words
    EMIT = 1'b1   // streaming W0..W(N-1) downstream
  } sched_state_e;

  // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_scheduler_sched_expand.sv
// sched_expand
//   Combinational SHA-256 message-expansion step. Given the oldest word of
//   the 16-word window (w0 = W[t]) and the taps w1 = W[t+1], w9 = W[t+9],
//   w14 = W[t+14], returns W[t+16] modulo 2^32.
// Ports:
//   w0, w1, w9, w14 : input  32-bit window taps
//   w_new           : output 32-bit expanded word
module sched_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w_new
);

  // 32-bit sum: carries out of bit 31 are dropped, giving mod 2^32.
  assign w_new = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/message_scheduler.sv
// message_scheduler
//   Accepts one 512-bit message block as 16 serial 32-bit words (first word
//   = most significant) and then streams the SHA-256 message schedule
//   W0..W(NUM_ROUNDS-1), one word per accepted handshake, with its round
//   index. A 16-entry shift window holds W[t]..W[t+15]; every accepted output
//   word shifts the window and appends W[t+16], so the head of the window is
//   always the word currently presented.
// Parameters:
//   NUM_ROUNDS : schedule words emitted per block, legal range 16..64
// Ports:
//   clk        : input  system clock, rising edge
//   rst        : input  synchronous active-high reset
//   blk_valid  : input  blk_word carries a message word
//   blk_ready  : output scheduler is accepting message words
//   blk_word   : input  32-bit message word
//   w_valid    : output w_word/w_round/w_last are valid
//   w_ready    : input  downstream takes the word this cycle
//   w_word     : output schedule word W_t
//   w_round    : output t
//   w_last     : output t == NUM_ROUNDS-1 (qualified by w_valid)
//   done       : output one-cycle pulse after the last word is accepted
module message_scheduler
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_round,
  output logic        w_last,
  output logic        done
);

  localparam logic [4:0] LOAD_LAST  = 5'(BLOCK_WORDS - 1);
  localparam logic [5:0] ROUND_LAST = 6'(NUM_ROUNDS - 1);

  sched_state_e state_q, state_d;
  logic [4:0]   load_cnt_q, load_cnt_d;
  logic [5:0]   round_q, round_d;
  logic         done_q, done_d;

  // Window: win_q[0] is the oldest word (the one presented downstream).
  logic [31:0]  win_q [BLOCK_WORDS];
  logic [31:0]  win_d [BLOCK_WORDS];

  logic         shift_en;
  logic [31:0]  shift_word;
  logic [31:0]  expand_word;

  sched_expand u_expand (
    .w0    (win_q[0]),
    .w1    (win_q[1]),
    .w9    (win_q[9]),
    .w14   (win_q[14]),
    .w_new (expand_word)
  );

  // Shift network: each entry takes its younger neighbour, the youngest
  // entry takes the incoming word (message word or expanded word).
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_win
      if (gi == BLOCK_WORDS - 1) begin : g_tail
        assign win_d[gi] = shift_en ? shift_word : win_q[gi];
      end else begin : g_body
        assign win_d[gi] = shift_en ? win_q[gi+1] : win_q[gi];
      end
    end
  endgenerate

  // Next-state / control
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    round_d    = round_q;
    done_d     = 1'b0;
    shift_en   = 1'b0;
    shift_word = blk_word;

    case (state_q)
      LOAD: begin
        if (blk_valid) begin
          shift_en   = 1'b1;
          shift_word = blk_word;
          if (load_cnt_q == LOAD_LAST) begin
            state_d    = EMIT;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 5'd1;
          end
        end
      end

      EMIT: begin
        if (w_ready) begin
          // Words beyond the block are generated one step ahead, so the
          // window always holds W[t]..W[t+15] while W[t] is presented.
          shift_en   = 1'b1;
          shift_word = expand_word;
          if (round_q == ROUND_LAST) begin
            state_d = LOAD;
            round_d = '0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 6'd1;
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      round_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      round_q    <= round_d;
      done_q     <= done_d;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // All outputs come straight from registers.
  assign blk_ready = (state_q == LOAD);
  assign w_valid   = (state_q == EMIT);
  assign w_word    = win_q[0];
  assign w_round   = round_q;
  assign w_last    = (state_q == EMIT) && (round_q == ROUND_LAST);
  assign done      = done_q;

endmodule

// File: tb/tb_message_scheduler.sv
module tb_message_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blk_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_round;
  logic        w_last;
  logic        done;

  message_scheduler #(.NUM_ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_word    (w_word),
    .w_round   (w_round),
    .w_last    (w_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] cur_blk  [16];
  logic [31:0] exp_w    [64];
  logic [31:0] got_word [64];
  int          got_round[64];
  logic        got_last [64];
  int          first_cyc;
  int          done_cyc;

  // ---------------- reference model (textbook SHA-256 schedule) ----------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = cur_blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
    build_model();
  endtask

  // ---------------- drivers / monitors ------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads cur_blk; gap_pct = percentage of cycles with blk_valid low.
  task automatic load_block(input int gap_pct);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    first_cyc = -1;
    while (idx < 16 && guard < 1000) begin
      blk_valid = ($urandom_range(99) >= gap_pct);
      blk_word  = blk_valid ? cur_blk[idx] : $urandom;
      if (blk_valid && blk_ready) begin
        if (idx == 0) first_cyc = cyc;
        idx++;
      end
      tick();
      guard++;
    end
    blk_valid = 1'b0;
    n_total++;
    if (idx != 16) $display("FAIL load_timeout: accepted %0d words, need 16", idx);
    else n_pass++;
  endtask

  // Collects stop_at words; stall_pct = percentage of cycles with w_ready
  // low; junk drives random blk_valid/blk_word throughout.
  task automatic collect(input int stall_pct, input bit junk, input int stop_at);
    int n;
    int guard;
    bit prev_stall;
    logic [31:0] held_word;
    logic [5:0]  held_round;
    n = 0;
    guard = 0;
    prev_stall = 1'b0;
    held_word = '0;
    held_round = '0;
    while (n < stop_at && guard < 3000) begin
      if (prev_stall) begin
        n_total++;
        if (w_word !== held_word || w_round !== held_round || w_valid !== 1'b1)
          $display("FAIL stall_stable: word=%h round=%0d valid=%b, need word=%h round=%0d valid=1",
                   w_word, w_round, w_valid, held_word, held_round);
        else n_pass++;
      end
      w_ready = ($urandom_range(99) >= stall_pct);
      if (junk) begin
        blk_valid = 1'b1;
        blk_word  = $urandom;
      end
      if (w_valid) begin
        if (w_ready) begin
          got_word[n]  = w_word;
          got_round[n] = int'(w_round);
          got_last[n]  = w_last;
          n++;
        end
        prev_stall = !w_ready;
        held_word  = w_word;
        held_round = w_round;
      end else begin
        prev_stall = 1'b0;
      end
      tick();
      guard++;
    end
    if (junk) blk_valid = 1'b0;
    n_total++;
    if (n != stop_at) $display("FAIL emit_timeout: got %0d words, need %0d", n, stop_at);
    else n_pass++;
    done_cyc = cyc;
    if (stop_at == 64) begin
      n_total++;
      if (done !== 1'b1 || blk_ready !== 1'b1 || w_valid !== 1'b0)
        $display("FAIL done_cycle: done=%b blk_ready=%b w_valid=%b, need 1 1 0",
                 done, blk_ready, w_valid);
      else n_pass++;
    end
  endtask

  task automatic check_words(input string name);
    for (int t = 0; t < 64; t++) begin
      n_total++;
      if (got_word[t] !== exp_w[t] || got_round[t] != t || got_last[t] !== (t == 63))
        $display("FAIL %s_w%0d: word=%h round=%0d last=%b, need word=%h round=%0d last=%b",
                 name, t, got_word[t], got_round[t], got_last[t], exp_w[t], t, (t == 63));
      else n_pass++;
    end
    $display("block %s: 64 words compared", name);
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0 || w_word !== 32'h0 ||
        w_round !== 6'd0 || w_last !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs: blk_ready=%b w_valid=%b w_word=%h w_round=%0d w_last=%b done=%b, need 1 0 0 0 0 0",
               blk_ready, w_valid, w_word, w_round, w_last, done);
    else n_pass++;
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_abc();
    set_abc();
    load_block(0);
    collect(0, 1'b0, 64);
    check_words("abc");
    n_total++;
    if (got_word[0] !== 32'h61626380 || got_word[15] !== 32'h00000018 ||
        got_word[16] !== 32'h61626380 || got_word[17] !== 32'h000F0000 ||
        got_word[18] !== 32'h7DA86405 || got_word[63] !== 32'h12B1EDEB)
      $display("FAIL abc_known: W0=%h W15=%h W16=%h W17=%h W18=%h W63=%h, need 61626380 00000018 61626380 000f0000 7da86405 12b1edeb",
               got_word[0], got_word[15], got_word[16], got_word[17], got_word[18], got_word[63]);
    else n_pass++;
    n_total++;
    if (got_last[63] !== 1'b1 || got_round[63] != 63)
      $display("FAIL abc_last: last=%b round=%0d, need 1 63", got_last[63], got_round[63]);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL done_pulse: done=%b one cycle later, need 0", done);
    else n_pass++;
  endtask

  task automatic test_zero();
    for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
    build_model();
    load_block(0);
    collect(0, 1'b0, 64);
    check_words("zero");
    n_total++;
    if (done_cyc - first_cyc != 80)
      $display("FAIL zero_latency: %0d cycles first accept to done, need 80", done_cyc - first_cyc);
    else n_pass++;
  endtask

  task automatic test_stalls();
    set_abc();
    load_block(35);
    collect(40, 1'b0, 64);
    check_words("abc_stall");
    set_random();
    load_block(20);
    collect(25, 1'b1, 64);
    check_words("rand_stall");
  endtask

  task automatic test_reset_mid();
    set_random();
    load_block(0);
    collect(0, 1'b0, 30);
    n_total++;
    if (w_valid !== 1'b1 || w_round !== 6'd30)
      $display("FAIL mid_round: w_valid=%b w_round=%0d, need 1 30", w_valid, w_round);
    else n_pass++;
    w_ready = 1'b0;
    rst = 1'b1;
    tick();
    n_total++;
    if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_round !== 6'd0 || done !== 1'b0)
      $display("FAIL mid_reset: w_valid=%b blk_ready=%b w_round=%0d done=%b, need 0 1 0 0",
               w_valid, blk_ready, w_round, done);
    else n_pass++;
    rst = 1'b0;
    set_abc();
    load_block(0);
    collect(0, 1'b0, 64);
    check_words("abc_after_reset");
  endtask

  task automatic test_back_to_back();
    int a_done;
    set_random();
    load_block(0);
    collect(0, 1'b1, 64);
    check_words("b2b_a");
    a_done = done_cyc;
    set_random();
    load_block(0);
    n_total++;
    if (first_cyc != a_done)
      $display("FAIL b2b_start: first accept at cycle %0d, need %0d", first_cyc, a_done);
    else n_pass++;
    collect(10, 1'b1, 64);
    check_words("b2b_b");
  endtask

  initial begin
    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_word  = '0;
    w_ready   = 1'b0;
    test_reset();
    test_abc();
    test_zero();
    test_stalls();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/message_scheduler.md
Name: message_scheduler

Overview:
Upstream feeder for the Sha256 core's per-round word input. It accepts one 512-bit message block as 16 serial 32-bit words, big-endian word order, with a valid/ready handshake. It then emits the full 64-word SHA-256 message schedule W0..W63, one word per round, with a round index and a stallable valid/ready handshake. The block provides the W_t stream that the round generator consumes alongside its round counter.

Parameters:
NUM_ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
blk_valid  input  1  blk_word holds a valid message word
blk_ready  output  1  block is accepting message words (LOAD state)
blk_word  input  32  message word; first word is the block's most significant word
w_valid  output  1  w_word/w_round valid
w_ready  input  1  downstream consumes the word this cycle
w_word  output  32  schedule word W_t
w_round  output  6  t, 0..NUM_ROUNDS-1
w_last  output  1  high with w_valid when t == NUM_ROUNDS-1
done  output  1  one-cycle pulse in the cycle after the last word is accepted

Behaviour:
- Reset (rst=1 at a clk edge): state=LOAD, window w[0..15]=0, load count=0, round=0.
- Reset outputs: blk_ready=1, w_valid=0, w_word=0, w_round=0, w_last=0, done=0.
- Reset mid-block or mid-emission aborts the block; no partial output follows.
- Storage: 16x32 shift window. w[0] is the oldest word. A shift moves w[i]<=w[i+1] and writes the new word into w[15].
- LOAD state:
  - blk_ready=1 and w_valid=0.
  - Each blk_valid&blk_ready cycle shifts blk_word into w[15] and increments the load count.
  - On the 16th accept, go to EMIT. The first word now sits in w[0].
  - blk_valid low stalls the load count without penalty.
- EMIT state:
  - blk_ready=0 and w_valid=1.
  - w_word=w[0] and w_round=round counter. Both are driven from registers; there is no combinational path from inputs.
  - On w_valid&w_ready: shift the window with new w[15]=sigma1(w[14])+w[9]+sigma0(w[1])+w[0], mod 2^32 (wrap, no carry-out). Then increment round.
  - When w_ready is low, all state holds and w_word/w_round stay stable.
  - Accepting round NUM_ROUNDS-1 moves to LOAD, clears round and load count, and pulses done the next cycle.
  - blk_ready returns high in that same next cycle.
- Latency:
  - The 16th load accept to w_valid=1 is 1 cycle.
  - With w_ready held high, 64 consecutive words are emitted on consecutive cycles.
  - One block completes in 16+64 cycles, minimum with no stalls.
- Functions: sigma0(x)=ROTR7(x)^ROTR18(x)^SHR3(x); sigma1(x)=ROTR17(x)^ROTR19(x)^SHR10(x).
- Words W16+ are computed one step ahead, so W_t for t<16 are the loaded words unchanged.
- blk_valid during EMIT is ignored, because blk_ready=0.
- w_ready during LOAD is ignored.
- Back-to-back blocks: a new load may begin in the cycle done is high.

Decomposition:
- Shared package sha256_pkg holds:
  - BLOCK_WORDS=16 and ROUNDS=64 constants.
  - The state enum {LOAD, EMIT}.
  - sigma0/sigma1 functions, reused by a future hash-output stage.
- One sub-module, sched_expand: combinational next-word generator taking w[0], w[1], w[9], w[14] and returning the 32-bit sum.
- Registers and FSM stay in the top.

Test Plan:
- "abc" padded block: load 0x61626380, 14 words of 0, then 0x00000018 with w_ready=1.
  - W0=0x61626380, W15=0x00000018.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
  - W63=0x12B1EDEB with w_last=1 and w_round=63.
  - done pulses 1 cycle later.
- All-zero block: all 64 w_word=0; w_round counts 0..63 on consecutive cycles; total 80 cycles from the first load accept to done.
- Stalls: "abc" block with w_ready toggled on a pseudo-random pattern, and blk_valid gapped during load.
  - Word sequence is identical to the no-stall run.
  - w_word/w_round are stable on every w_valid&!w_ready cycle.
- Reset mid-emission: assert rst at round 30.
  - Next cycle w_valid=0, blk_ready=1, round=0.
  - Reload of the "abc" block yields the correct W0..W63.
- Back-to-back: two blocks with block 2 loaded starting in the done cycle.
  - Block 2 words are not corrupted by block 1.
  - blk_word driven during EMIT has no effect.
